ysyx_23060096_rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the NPC register file. Two producers share the register file's single write port: the EXU (ALU results) and the LSU (load data). The block arbitrates between them with aging to prevent starvation and registers the winning write onto the port. It also keeps a per-register pending bitmap so the IDU can detect read-after-write hazards on both read addresses.

---
 rtl/ysyx_23060096_pkg.sv | 17 +
 rtl/ysyx_23060096_scoreboard.sv | 53 +++++
 rtl/ysyx_23060096_rf_wb_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the NPC register-file write-back path.
package ysyx_23060096_pkg;

  // Default widths of the register file.
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  // Width of the EXU aging counter.
  localparam int AGE_W = 4;

  // Identity of the requester that owns the write port in a given cycle.
  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// Pending-write bitmap for the register file: set on issue, cleared when the
// register file is written, read combinationally by the IDU on two ports.
module ysyx_23060096_scoreboard
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  output logic                  ra_busy,
  output logic                  rb_busy
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Next bitmap: clear first, then set, so a same-cycle set on the same
  // index wins. x0 is never pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != '0)) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Bitmap register; reset forgets every outstanding write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Read ports have no bypass: a write landing this cycle still reads busy.
  always_comb begin
    ra_busy = pending_q[ra];
    rb_busy = pending_q[rb];
  end

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port. LSU has
// default priority; an aging counter lets a refused EXU take the port after
// AGE_MAX refused cycles. The winning write is registered onto the port and
// a scoreboard tracks outstanding destinations for hazard detection.
//
// Handshake: a request transfers on a cycle where valid && ready. The
// requester holds valid/rd/data stable until it sees ready; ready depends
// only on both valids and the age counter (never on ready itself), at most
// one ready is high per cycle, and both readies are low while rstn is low.
module ysyx_23060096_rf_wb_arbiter
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AGE_MAX    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  output logic                  ra_busy,
  output logic                  rb_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0]      age_q;
  logic [AGE_W-1:0]      age_d;
  logic                  rf_wen_q;
  logic                  rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [DATA_WIDTH-1:0] rf_wdata_d;

  logic                  exu_wins;
  wb_src_e               grant_src;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  // Arbitration: EXU wins when alone or once it has aged out; otherwise LSU.
  always_comb begin
    exu_wins  = exu_valid && (!lsu_valid || (age_q == AGE_LIMIT));
    exu_ready = rstn && exu_wins;
    lsu_ready = rstn && lsu_valid && !exu_wins;
    grant_src = exu_wins ? WB_EXU : WB_LSU;
    xfer      = (exu_valid && exu_ready) || (lsu_valid && lsu_ready);
    sel_rd    = (grant_src == WB_EXU) ? exu_rd : lsu_rd;
    sel_data  = (grant_src == WB_EXU) ? exu_data : lsu_data;
  end

  // Age counts refused EXU cycles, saturating; any EXU transfer or idle
  // EXU restarts it.
  always_comb begin
    age_d = age_q;
    if (!exu_valid || exu_ready) begin
      age_d = '0;
    end else if (age_q != AGE_LIMIT) begin
      age_d = age_q + 1'b1;
    end
  end

  // Write stage: a transfer loads address/data; writes to x0 are dropped by
  // keeping the enable low. Address/data hold when idle.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_wen_d   = (sel_rd != '0);
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  // Age counter and write register; reset drops any accepted write in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      age_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      age_q      <= age_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Port drivers for the registered write.
  always_comb begin
    rf_wen   = rf_wen_q;
    rf_waddr = rf_waddr_q;
    rf_wdata = rf_wdata_q;
  end

  ysyx_23060096_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rstn    (rstn),
    .set_en  (issue_en),
    .set_idx (issue_rd),
    .clr_en  (rf_wen_q),
    .clr_idx (rf_waddr_q),
    .ra      (ra),
    .rb      (rb),
    .ra_busy (ra_busy),
    .rb_busy (rb_busy)
  );

endmodule
